uart_reg_bridge: RTL

Command parser and responder on the host side of the byte UART. Consumes received bytes, decodes short ASCII read/write commands into a simple register bus (feeding PWM control registers), and sends ASCII replies back through the UART's transmit handshake. Sits between the `uart` instance and the PWM register file.

---
 rtl/uart_cmd_pkg.sv | 59 +++++
 rtl/reply_tx.sv | 69 ++++++
 rtl/uart_reg_bridge.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encodings and ASCII hex helpers for the UART
// command bridge.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_W    = 8'h57;
  localparam logic [7:0] ASCII_W_LC = 8'h77;
  localparam logic [7:0] ASCII_R    = 8'h52;
  localparam logic [7:0] ASCII_R_LC = 8'h72;
  localparam logic [7:0] ASCII_K    = 8'h4B;
  localparam logic [7:0] ASCII_QM   = 8'h3F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_GET_CR,
    ST_DISCARD,
    ST_EXEC,
    ST_READ_WAIT,
    ST_SEND
  } parse_state_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_REQ,
    TX_DROP
  } tx_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_nib_t;

  function automatic hex_nib_t hex_to_nib(input logic [7:0] c);
    hex_nib_t r;
    r.valid = 1'b1;
    r.nib   = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)
      r.nib = c[3:0];
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r.nib = c[3:0] + 4'd9;
    else
      r.valid = 1'b0;
    return r;
  endfunction

  // Replies always use uppercase hex digits.
  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    if (n < 4'd10)
      return 8'h30 + {4'h0, n};
    else
      return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/reply_tx.sv
// Reply sequencer: holds up to three reply bytes and hands them one at a
// time to the UART through the transmit / is_transmitting handshake.
module reply_tx
  import uart_cmd_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [1:0]      load_len,
  input  logic [2:0][7:0] load_data,
  input  logic            is_transmitting,
  output logic [7:0]      tx_byte,
  output logic            transmit,
  output logic            busy
);

  tx_state_t       state;
  logic [2:0][7:0] pend_q;
  logic [1:0]      left_q;

  assign busy = (state != TX_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= TX_IDLE;
      pend_q   <= '0;
      left_q   <= 2'd0;
      tx_byte  <= 8'h00;
      transmit <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (load && load_len != 2'd0) begin
            tx_byte  <= load_data[0];
            pend_q   <= {8'h00, load_data[2], load_data[1]};
            left_q   <= load_len - 2'd1;
            transmit <= 1'b1;
            state    <= TX_REQ;
          end
        end
        TX_REQ: begin
          if (is_transmitting) begin
            transmit <= 1'b0;
            state    <= TX_DROP;
          end
        end
        TX_DROP: begin
          // Request is already released, so the UART cannot resend this byte.
          if (!is_transmitting) begin
            if (left_q != 2'd0) begin
              tx_byte  <= pend_q[0];
              pend_q   <= {8'h00, pend_q[2], pend_q[1]};
              left_q   <= left_q - 2'd1;
              transmit <= 1'b1;
              state    <= TX_REQ;
            end else begin
              state <= TX_IDLE;
            end
          end
        end
        default: begin
          transmit <= 1'b0;
          state    <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_reg_bridge.sv
// ASCII command parser bridging UART bytes to an 8-bit register bus,
// with inter-byte timeout and ASCII replies via reply_tx.
//
// state        | meaning
// ST_IDLE      | waiting for a command letter
// ST_ADDR_HI   | expecting address high nibble
// ST_ADDR_LO   | expecting address low nibble
// ST_DATA_HI   | expecting write data high nibble
// ST_DATA_LO   | expecting write data low nibble
// ST_GET_CR    | expecting terminating CR
// ST_DISCARD   | malformed command, swallowing until CR
// ST_EXEC      | bus strobe visible, choose reply
// ST_READ_WAIT | read data valid, load hex reply
// ST_SEND      | reply in flight
module uart_reg_bridge
  import uart_cmd_pkg::*;
#(
  parameter int NUM_REGS    = 16,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1_200_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_byte,
  input  logic              received,
  input  logic              recv_error,
  output logic [7:0]        tx_byte,
  output logic              transmit,
  input  logic              is_transmitting,
  output logic [7:0]        reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              overrun
);

  localparam int               TMR_W      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(TIMEOUT_CYC);
  localparam logic [8:0]       NUM_REGS_W = 9'(NUM_REGS);

  parse_state_t    state;
  logic            is_write_q;
  logic            cmd_ok_q;
  logic [7:0]      addr_q;
  logic [7:0]      data_q;
  logic [TMR_W-1:0] tmr_q;
  logic            load_q;
  logic [1:0]      rep_len_q;
  logic [2:0][7:0] rep_q;

  hex_nib_t        hx;
  logic            timed;
  logic            load;
  logic [1:0]      load_len;
  logic [2:0][7:0] load_data;
  logic            tx_busy;

  always_comb begin
    hx        = hex_to_nib(rx_byte);
    timed     = (state inside {ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO,
                               ST_GET_CR, ST_DISCARD});
    load      = load_q;
    load_len  = rep_len_q;
    load_data = rep_q;
    // Read data is converted on the fly so the first reply byte is not delayed.
    if (state == ST_READ_WAIT) begin
      load      = 1'b1;
      load_len  = 2'd3;
      load_data = {ASCII_CR, nib_to_hex(reg_rdata[3:0]), nib_to_hex(reg_rdata[7:4])};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      is_write_q <= 1'b0;
      cmd_ok_q   <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      tmr_q      <= '0;
      load_q     <= 1'b0;
      rep_len_q  <= 2'd0;
      rep_q      <= '0;
      reg_addr   <= 8'h00;
      reg_wdata  <= '0;
      reg_we     <= 1'b0;
      reg_re     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      reg_re <= 1'b0;
      load_q <= 1'b0;

      if (received && (state inside {ST_EXEC, ST_READ_WAIT, ST_SEND}))
        overrun <= 1'b1;

      if (received)
        tmr_q <= TMR_RELOAD;
      else if (timed && tmr_q != '0)
        tmr_q <= tmr_q - 1'b1;

      case (state)
        ST_IDLE: begin
          if (received) begin
            if (rx_byte == ASCII_W || rx_byte == ASCII_W_LC) begin
              is_write_q <= 1'b1;
              state      <= ST_ADDR_HI;
            end else if (rx_byte == ASCII_R || rx_byte == ASCII_R_LC) begin
              is_write_q <= 1'b0;
              state      <= ST_ADDR_HI;
            end else if (rx_byte != ASCII_CR && rx_byte != ASCII_LF) begin
              state <= ST_DISCARD;
            end
          end
        end

        ST_ADDR_HI, ST_ADDR_LO, ST_DATA_HI, ST_DATA_LO: begin
          if (recv_error) begin
            state <= ST_DISCARD;
          end else if (received) begin
            if (rx_byte == ASCII_CR) begin
              rep_q     <= {8'h00, ASCII_CR, ASCII_QM};
              rep_len_q <= 2'd2;
              load_q    <= 1'b1;
              state     <= ST_SEND;
            end else if (rx_byte != ASCII_LF) begin
              if (!hx.valid) begin
                state <= ST_DISCARD;
              end else begin
                case (state)
                  ST_ADDR_HI: begin
                    addr_q[7:4] <= hx.nib;
                    state       <= ST_ADDR_LO;
                  end
                  ST_ADDR_LO: begin
                    addr_q[3:0] <= hx.nib;
                    state       <= is_write_q ? ST_DATA_HI : ST_GET_CR;
                  end
                  ST_DATA_HI: begin
                    data_q[7:4] <= hx.nib;
                    state       <= ST_DATA_LO;
                  end
                  default: begin
                    data_q[3:0] <= hx.nib;
                    state       <= ST_GET_CR;
                  end
                endcase
              end
            end
          end else if (tmr_q == '0) begin
            state <= ST_IDLE;
          end
        end

        ST_GET_CR: begin
          if (recv_error) begin
            state <= ST_DISCARD;
          end else if (received) begin
            if (rx_byte == ASCII_CR) begin
              // Strobe is issued here so it is visible the cycle after the CR.
              if ({1'b0, addr_q} < NUM_REGS_W) begin
                cmd_ok_q <= 1'b1;
                reg_addr <= addr_q;
                if (is_write_q) begin
                  reg_wdata <= DATA_W'(data_q);
                  reg_we    <= 1'b1;
                end else begin
                  reg_re <= 1'b1;
                end
              end else begin
                cmd_ok_q <= 1'b0;
              end
              state <= ST_EXEC;
            end else if (rx_byte != ASCII_LF) begin
              state <= ST_DISCARD;
            end
          end else if (tmr_q == '0) begin
            state <= ST_IDLE;
          end
        end

        ST_DISCARD: begin
          if (received) begin
            if (rx_byte == ASCII_CR) begin
              rep_q     <= {8'h00, ASCII_CR, ASCII_QM};
              rep_len_q <= 2'd2;
              load_q    <= 1'b1;
              state     <= ST_SEND;
            end
          end else if (tmr_q == '0) begin
            state <= ST_IDLE;
          end
        end

        ST_EXEC: begin
          if (!cmd_ok_q) begin
            rep_q     <= {8'h00, ASCII_CR, ASCII_QM};
            rep_len_q <= 2'd2;
            load_q    <= 1'b1;
            state     <= ST_SEND;
          end else if (is_write_q) begin
            rep_q     <= {8'h00, ASCII_CR, ASCII_K};
            rep_len_q <= 2'd2;
            load_q    <= 1'b1;
            state     <= ST_SEND;
          end else begin
            state <= ST_READ_WAIT;
          end
        end

        ST_READ_WAIT: begin
          state <= ST_SEND;
        end

        ST_SEND: begin
          // load_q guards the cycle before the sequencer reports busy.
          if (!load_q && !tx_busy)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  reply_tx u_reply_tx (
    .clk             (clk),
    .rst             (rst),
    .load            (load),
    .load_len        (load_len),
    .load_data       (load_data),
    .is_transmitting (is_transmitting),
    .tx_byte         (tx_byte),
    .transmit        (transmit),
    .busy            (tx_busy)
  );

endmodule
